alu_issue_wb: RTL
=================

# alu_issue_wb

Issue and write-back front end for the 8-bit pipelined ALU. Accepts 16-bit instruction words over a valid/ready handshake and reads operands from a 4×8 register file. Drives the ALU's `A`, `B`, `instr` and `branch_addr` inputs from registers, then captures the ALU's registered result one cycle later to write back the register file, update carry status and resolve branches. It stalls on read-after-write hazards instead of forwarding.

## Interface
Parameters:
- `NREG`, 4: register-file depth, fixed; 2-bit register specifiers.
- `W`, 8: datapath width, fixed to match the ALU.

Ports:
- `CLK`  in  1  rising-edge clock; shared with the ALU.
- `RST`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  instruction word present.
- `in_instr`  in  16  instruction word. Fields: `[15:13]` op, `[12:11]` rd, `[10:9]` rs1, `[8:7]` rs2, `[5:0]` branch target (BEQ only).
- `in_ready`  out  1  block can accept this cycle.
- `alu_a`, `alu_b`  out  8  operand registers to the ALU's `A` and `B`.
- `alu_instr`  out  3  op register to the ALU's `instr`.
- `alu_branch_addr`  out  6  to the ALU's `branch_addr`.
- `alu_out`  in  8  ALU result.
- `alu_co`  in  1  ALU carry/borrow.
- `alu_branch`  in  1  ALU branch flag.
- `carry_q`  out  1  last ADD/SUB carry.
- `redirect_valid`  out  1  one-cycle pulse: branch taken.
- `redirect_target`  out  6  branch target.
- `dbg_addr`  in  2  debug register select.
- `dbg_data`  out  8  combinational read of `reg[dbg_addr]`.

## Operation
- Ops:
  - 000 NOP
  - 001 ADD
  - 010 SUB
  - 011 AND
  - 100 NOT (rs1 only)
  - 101 OR
  - 110 CMP
  - 111 BEQ
- Write-back:
  - Ops 001–110 write `alu_out` to rd.
  - NOP and BEQ write nothing.
  - ADD/SUB also load `alu_co` into `carry_q`.
  - Other ops leave `carry_q` unchanged.
- Pipeline stages:
  - **IS**: issue registers `is_v`, `is_rd`, `is_wr`, `is_op`. They drive the `alu_*` ports.
  - **EX**: `ex_v`, `ex_rd`, `ex_wr`, `ex_op`. These track the instruction whose result appears on `alu_out`.
- Accept occurs when `in_valid && in_ready`. On accept:
  - rs1/rs2 are read combinationally from the register file.
  - Operands load into `alu_a`/`alu_b`, op into `alu_instr`, `[5:0]` into `alu_branch_addr`, and `is_v` is set.
- When nothing is accepted:
  - `alu_instr` is loaded with 000, `is_v` is cleared, and `alu_a`/`alu_b` hold.
  - Bubbles are therefore always ALU NOPs.
- Every cycle, IS shifts into EX. When `ex_v && ex_wr`, `alu_out` is written to `reg[ex_rd]` on that edge.
- `in_ready` is 0 when any of these holds:
  - A source register (rs1, plus rs2 unless op is NOT/NOP/BEQ) equals `is_rd` with `is_v && is_wr`.
  - The same match against `ex_rd` with `ex_v && ex_wr`.
  - `redirect_valid` is 1 this cycle.
  - Otherwise `in_ready` is 1.
- Branch resolution:
  - When `ex_v`, `ex_op==111` and `alu_out!=0`, the branch is taken.
  - On a taken branch: `redirect_valid`=1 and `redirect_target`=`alu_out[5:0]`, registered so they appear the cycle after EX.
  - The IS entry is squashed: `is_v`=0 and `alu_instr` is forced to 000 on that edge.
  - Target 6'd0 is reserved and always reads as not-taken.
  - `alu_branch` is informational only; the block does not use it.
- BEQ consumes the ALU's own eq flag. Program order must place CMP immediately before BEQ; the block does not enforce this.

## Timing
- Accept at edge n: `alu_*` valid during cycle n+1. The ALU samples at edge n+1, `alu_out` is valid in cycle n+2, and write-back occurs at edge n+2.
- A dependent read is allowed from edge n+2 onward; the register-file write at edge n+2 is visible to the combinational read in cycle n+2. Back-to-back dependent instructions therefore stall 2 cycles.
- Independent instructions issue at 1 per cycle.
- Branch taken: `redirect_valid` is high in cycle n+3 for exactly 1 cycle, and `in_ready` is 0 in that cycle.
- Reset values:
  - All registers 0.
  - `is_v`, `ex_v` = 0.
  - `alu_a`, `alu_b`, `alu_branch_addr` = 0; `alu_instr` = 000.
  - `carry_q`, `redirect_valid`, `redirect_target` = 0.
  - `in_ready` = 1 after reset deasserts.
- Reset mid-operation discards IS and EX. No write-back occurs on the reset edge.
- Simultaneous write-back and dbg read of the same register: `dbg_data` shows the old value until the edge.

## Test plan
- After reset, load r1 and r2 by CMP trick or preload: ADD r3=r1+r2 with r1=200, r2=100 → r3=44, `carry_q`=1 at write-back edge.
- ADD r1,r1,r2 immediately followed by OR r2,r1,r0 → `in_ready` low exactly 2 cycles; OR sees the updated r1.
- 4 independent ops back to back → `in_ready` stays 1; `alu_instr` sequence matches with 1-cycle spacing; no NOP gaps.
- CMP r0,r1 (equal, 0==0), then BEQ target 6'd21, then a younger ADD → `redirect_valid` pulse with target 21; the ADD is squashed and its rd is unchanged.
- CMP unequal, then BEQ target 21 → no redirect; subsequent instructions complete normally.
- Assert `RST` with IS and EX both valid → the next cycle `alu_instr`=000, there is no write-back, and all `dbg_data` reads return 0.

Source files
------------

// File: rtl/alu_issue_wb.sv
// rtl/alu_issue_wb.sv - issue/write-back front end for the 8-bit pipelined ALU
// Two-stage tracking (IS, EX); stalls on RAW hazards; squashes younger work on a taken BEQ.
module alu_issue_wb #(
  parameter int NREG = 4,
  parameter int W    = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_valid,
  input  logic [15:0]  in_instr,
  output logic         in_ready,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_instr,
  output logic [5:0]   alu_branch_addr,
  input  logic [W-1:0] alu_out,
  input  logic         alu_co,
  input  logic         alu_branch,
  output logic         carry_q,
  output logic         redirect_valid,
  output logic [5:0]   redirect_target,
  input  logic [1:0]   dbg_addr,
  output logic [W-1:0] dbg_data
);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_NOT = 3'd4;
  localparam logic [2:0] OP_BEQ = 3'd7;

  logic [W-1:0] rf [NREG];

  logic       is_v, is_wr, ex_v, ex_wr;
  logic [1:0] is_rd, ex_rd;
  logic [2:0] is_op, ex_op;

  logic [2:0] op_in;
  logic [1:0] rd_in, rs1_in, rs2_in;
  logic       wr_in, use_rs2, haz_is, haz_ex, taken, accept;
  logic       unused_in;

  assign op_in  = in_instr[15:13];
  assign rd_in  = in_instr[12:11];
  assign rs1_in = in_instr[10:9];
  assign rs2_in = in_instr[8:7];

  // alu_branch is informational and bit 6 of the instruction word is unassigned
  assign unused_in = ^{alu_branch, in_instr[6]};

  assign wr_in   = (op_in != OP_NOP) && (op_in != OP_BEQ);
  assign use_rs2 = (op_in != OP_NOT) && (op_in != OP_NOP) && (op_in != OP_BEQ);

  assign haz_is = is_v && is_wr &&
                  ((rs1_in == is_rd) || (use_rs2 && (rs2_in == is_rd)));
  assign haz_ex = ex_v && ex_wr &&
                  ((rs1_in == ex_rd) || (use_rs2 && (rs2_in == ex_rd)));

  assign in_ready = !(haz_is || haz_ex || redirect_valid);
  assign accept   = in_valid && in_ready;

  // A zero target is reserved, so only a non-zero low field counts as taken
  assign taken = ex_v && (ex_op == OP_BEQ) && (alu_out[5:0] != 6'd0);

  assign alu_instr = is_op;
  assign dbg_data  = rf[dbg_addr];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      is_v            <= 1'b0;
      is_wr           <= 1'b0;
      is_rd           <= 2'd0;
      is_op           <= OP_NOP;
      ex_v            <= 1'b0;
      ex_wr           <= 1'b0;
      ex_rd           <= 2'd0;
      ex_op           <= OP_NOP;
      alu_a           <= '0;
      alu_b           <= '0;
      alu_branch_addr <= 6'd0;
      carry_q         <= 1'b0;
      redirect_valid  <= 1'b0;
      redirect_target <= 6'd0;
    end else begin
      // The IS entry moving into EX on a taken branch is younger, so it is killed
      ex_v  <= is_v && !taken;
      ex_wr <= is_wr;
      ex_rd <= is_rd;
      ex_op <= is_op;

      if (ex_v && ex_wr) begin
        rf[ex_rd] <= alu_out;
        if ((ex_op == OP_ADD) || (ex_op == OP_SUB)) carry_q <= alu_co;
      end

      redirect_valid <= taken;
      if (taken) redirect_target <= alu_out[5:0];

      if (accept && !taken) begin
        is_v            <= 1'b1;
        is_wr           <= wr_in;
        is_rd           <= rd_in;
        is_op           <= op_in;
        alu_a           <= rf[rs1_in];
        alu_b           <= rf[rs2_in];
        alu_branch_addr <= in_instr[5:0];
      end else begin
        is_v  <= 1'b0;
        is_wr <= 1'b0;
        is_op <= OP_NOP;
      end
    end
  end

endmodule
